rr_burst_arbiter: RTL and testbench
===================================

Name: rr_burst_arbiter

Overview:
- Sequential round-robin arbiter that shares one downstream resource (bus/datapath port) among NUM_PORTS requesters.
- Grant is registered and held for a multi-beat burst until last beat, request withdrawal, or hold-limit expiry; priority then rotates past the served port.
- Replaces the combinational fixed-priority arbiter wherever fairness and burst locking are needed. It sits between requester ports and the shared resource's ack/last handshake.

Parameters:
- NUM_PORTS, 4, number of requesters; legal range 2..32.
- MAX_HOLD, 16, maximum acknowledged beats per grant before forced release; legal range 1..255.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_i  input  NUM_PORTS  request per port; bit i = port i; level-sensitive.
- ack_i  input  1  shared resource accepted one beat from the granted port this cycle.
- last_i  input  1  qualifies ack_i; marks the final beat of the burst.
- gnt_o  output  NUM_PORTS  registered one-hot grant, or all-zero.
- gnt_valid_o  output  1  equals |gnt_o.
- gnt_id_o  output  $clog2(NUM_PORTS)  index of the granted port; 0 when gnt_valid_o=0.

Behaviour:
- Reset (rst_ni=0, asynchronous): gnt_o=0, gnt_valid_o=0, gnt_id_o=0, pointer ptr=0, beat counter=0, state IDLE.
  - A reset asserted mid-burst drops the grant immediately, with no completion.
- Priority order: circular, starting at ptr. Winner = first i in ptr, ptr+1, ..., ptr+N-1 (mod N) with req_i[i]=1.
- IDLE state:
  - If req_i != 0 at a rising edge, move to BUSY and register the winner into gnt_o, gnt_id_o, gnt_valid_o=1.
  - Latency is 1 cycle from request to grant. Beat counter clears to 0.
- BUSY state, granted port g. Each cycle, evaluate in this order:
  - Release condition: (ack_i & last_i), or req_i[g]=0, or (ack_i & counter==MAX_HOLD-1).
  - If not released: counter increments on ack_i; the grant is unchanged even if higher-priority requests appear (no preemption).
  - On release: ptr <= (g+1) mod N. At the same edge, arbitrate req_i using the new ptr.
    - If any request (other than g's, see below) is present: stay BUSY with the new winner, and the counter clears. Back-to-back bursts have no bubble cycle.
    - Otherwise: go to IDLE and gnt_o=0.
  - Released port g has lowest priority at the re-arbitration edge. It wins only if it is the sole requester, which makes it eligible for an immediate re-grant.
- ack_i and last_i are ignored in IDLE. last_i without ack_i is ignored.
- Counter width: 8 bits. Forced release fires on the MAX_HOLD-th ack. With MAX_HOLD=1, every ack releases.
- gnt_o is always one-hot or zero. gnt_id_o is always consistent with gnt_o.
- No combinational path from req_i, ack_i, or last_i to any output.

Test Plan (NUM_PORTS=4, MAX_HOLD=4):
- Reset/idle: rst_ni low, then high with req_i=0000 for 5 cycles -> gnt_o=0000, gnt_valid_o=0, gnt_id_o=0 throughout.
- Rotation: req_i=1111 held; issue ack_i&last_i once per grant -> grants go 0001, 0010, 0100, 1000, 0001 on consecutive bursts, with no idle cycle between them.
- Burst lock: grant port 2, then raise req_i[0] and issue 2 acks without last -> gnt_o stays 0100; an ack with last -> next edge gnt_o=1000 (ptr=3 wins over port 0).
- Hold limit: port 1 sole requester, acks every cycle, last_i=0 -> release after the 4th ack. Because port 1 is alone, it is re-granted next edge with counter=0. Repeating with req_i=0011 instead -> grant moves to port 0 after the 4th ack.
- Withdrawal and spurious handshake: port 3 granted, then req_i[3] drops with no ack -> next edge grant goes to the next requester or 0000. ack_i=1, last_i=1 while IDLE -> no state change.
- Async reset mid-burst: rst_ni pulsed low between clock edges while gnt_o=0100 -> gnt_o=0000 immediately. After release with req_i=1111 -> first grant is 0001 (ptr reset to 0).

Source files
------------

// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter
//   Round-robin arbiter with burst locking for one shared downstream resource.
//   A registered grant is held until the burst completes (ack_i & last_i), the
//   granted port withdraws its request, or MAX_HOLD beats have been acknowledged.
//   On release, priority rotates to the port after the one just served, and a new
//   winner is granted on the same edge (no bubble between bursts).
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   req_i        per-port request, level sensitive
//   ack_i        resource accepted a beat from the granted port this cycle
//   last_i       qualifies ack_i; final beat of the burst
//   gnt_o        registered one-hot grant, or zero
//   gnt_valid_o  |gnt_o
//   gnt_id_o     index of the granted port, 0 when no grant
module rr_burst_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned MAX_HOLD  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_PORTS-1:0]         req_i,
  input  logic                         ack_i,
  input  logic                         last_i,
  output logic [NUM_PORTS-1:0]         gnt_o,
  output logic                         gnt_valid_o,
  output logic [$clog2(NUM_PORTS)-1:0] gnt_id_o
);

  localparam int unsigned IdW = $clog2(NUM_PORTS);
  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);
  localparam logic [NUM_PORTS-1:0] OneHot0 = {{(NUM_PORTS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state;
  logic [IdW-1:0]   ptr;
  logic [7:0]       cnt;

  logic [IdW-1:0]   next_ptr;
  logic [IdW-1:0]   start;
  logic [IdW-1:0]   idx;
  logic [IdW-1:0]   win_id;
  logic             win_found;
  logic             release_now;

  // Pointer that takes effect if the current grant is released this cycle.
  always_comb begin
    next_ptr = '0;
    if (gnt_id_o != IdW'(NUM_PORTS - 1)) begin
      next_ptr = gnt_id_o + 1'b1;
    end
  end

  // In IDLE arbitrate from ptr; in BUSY arbitrate from the post-release pointer so
  // the port being released is searched last and only wins as sole requester.
  always_comb begin
    start     = (state == StIdle) ? ptr : next_ptr;
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = IdW'((32'(start) + k) % NUM_PORTS);
      if (!win_found && req_i[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  assign release_now = (ack_i & last_i) | ~req_i[gnt_id_o] | (ack_i & (cnt == HoldLast));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= StIdle;
      ptr         <= '0;
      cnt         <= '0;
      gnt_o       <= '0;
      gnt_valid_o <= 1'b0;
      gnt_id_o    <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          // ack_i/last_i have no meaning without a grant.
          if (win_found) begin
            state       <= StBusy;
            cnt         <= '0;
            gnt_o       <= OneHot0 << win_id;
            gnt_valid_o <= 1'b1;
            gnt_id_o    <= win_id;
          end
        end
        StBusy: begin
          if (release_now) begin
            ptr <= next_ptr;
            cnt <= '0;
            if (win_found) begin
              gnt_o       <= OneHot0 << win_id;
              gnt_valid_o <= 1'b1;
              gnt_id_o    <= win_id;
            end else begin
              state       <= StIdle;
              gnt_o       <= '0;
              gnt_valid_o <= 1'b0;
              gnt_id_o    <= '0;
            end
          end else if (ack_i) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed, table-driven bench for rr_burst_arbiter with NUM_PORTS=4, MAX_HOLD=4.
// Each table row is applied just after a rising edge and its expected registered
// outputs are compared one time unit after the following rising edge.
module tb_rr_burst_arbiter;

  logic       clk_i;
  logic       rst_ni;
  logic [3:0] req_i;
  logic       ack_i;
  logic       last_i;
  logic [3:0] gnt_o;
  logic       gnt_valid_o;
  logic [1:0] gnt_id_o;

  int n_tests;
  int n_fail;

  rr_burst_arbiter #(
    .NUM_PORTS(4),
    .MAX_HOLD (4)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .ack_i      (ack_i),
    .last_i     (last_i),
    .gnt_o      (gnt_o),
    .gnt_valid_o(gnt_valid_o),
    .gnt_id_o   (gnt_id_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic       last;
    logic [3:0] gnt;
    logic [1:0] id;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] req, input logic ack, input logic last,
                              input logic [3:0] gnt, input logic [1:0] id);
    vec_t v;
    v.req  = req;
    v.ack  = ack;
    v.last = last;
    v.gnt  = gnt;
    v.id   = id;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] exp_gnt, input logic [1:0] exp_id);
    logic exp_valid;
    exp_valid = (exp_gnt != 4'b0000);
    n_tests++;
    if (gnt_o !== exp_gnt || gnt_id_o !== exp_id || gnt_valid_o !== exp_valid) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b id=%0d valid=%b, expected gnt=%b id=%0d valid=%b",
               name, gnt_o, gnt_id_o, gnt_valid_o, exp_gnt, exp_id, exp_valid);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_ni  = 1'b0;
    req_i   = 4'b0000;
    ack_i   = 1'b0;
    last_i  = 1'b0;

    // Reset / idle
    repeat (5) add(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0);
    // Rotation with one-beat bursts, no idle gap
    add(4'b1111, 1'b0, 1'b0, 4'b0001, 2'd0);
    add(4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1);
    add(4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2);
    add(4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3);
    add(4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0);
    // Port 0 withdraws, nobody else requests -> idle (ptr=1)
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0);
    // Spurious handshake while idle
    add(4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0);
    // Burst lock on port 2; ports 0 and 3 arrive but cannot preempt
    add(4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2);
    add(4'b1101, 1'b1, 1'b0, 4'b0100, 2'd2);
    add(4'b1101, 1'b1, 1'b0, 4'b0100, 2'd2);
    add(4'b1101, 1'b1, 1'b1, 4'b1000, 2'd3);
    // Port 3 withdraws without ack -> ptr=0, port 0 wins; then all drop
    add(4'b0101, 1'b0, 1'b0, 4'b0001, 2'd0);
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0);
    add(4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0);
    // Hold limit, port 1 alone: release on 4th ack, immediate re-grant
    add(4'b0010, 1'b0, 1'b0, 4'b0010, 2'd1);
    add(4'b0010, 1'b1, 1'b0, 4'b0010, 2'd1);
    add(4'b0010, 1'b1, 1'b0, 4'b0010, 2'd1);
    add(4'b0010, 1'b1, 1'b0, 4'b0010, 2'd1);
    add(4'b0010, 1'b1, 1'b0, 4'b0010, 2'd1);
    // Counter restarted at 0: 3 acks hold, 4th forces release to port 0
    add(4'b0011, 1'b1, 1'b0, 4'b0010, 2'd1);
    add(4'b0011, 1'b1, 1'b0, 4'b0010, 2'd1);
    add(4'b0011, 1'b1, 1'b0, 4'b0010, 2'd1);
    add(4'b0011, 1'b1, 1'b0, 4'b0001, 2'd0);
    // last_i without ack_i is ignored
    add(4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0);
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0);
    // ptr=1 now; port 2 granted for the reset test
    add(4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2);

    repeat (3) @(posedge clk_i);
    #1;
    check("in_reset", 4'b0000, 2'd0);
    rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      req_i  = vecs[i].req;
      ack_i  = vecs[i].ack;
      last_i = vecs[i].last;
      @(posedge clk_i);
      #1;
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id);
    end

    // Asynchronous reset between edges drops the grant at once and clears ptr
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_reset_drop", 4'b0000, 2'd0);
    #1;
    rst_ni = 1'b1;
    req_i  = 4'b1111;
    ack_i  = 1'b0;
    last_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("post_reset_first", 4'b0001, 2'd0);
    ack_i  = 1'b1;
    last_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("post_reset_second", 4'b0010, 2'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
